// File: rtl/mips_defs.sv
// mips_defs: shared encodings for the MIPS EX stage.
//   - aluop classes driven by the control unit
//   - R-type funct codes understood by the ALU
//   - 4-bit ALU control codes, including INVALID
//   - bit positions inside the wb_ctl / m_ctl bundles
package mips_defs;

    typedef enum logic [1:0] {
        ALUOP_MEM   = 2'b00,   // lw/sw address add
        ALUOP_BEQ   = 2'b01,   // beq compare via subtract
        ALUOP_RTYPE = 2'b10,   // decode funct
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_INV = 4'b1111
    } alu_ctl_e;

    // wb_ctl = {regwrite, memtoreg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // m_ctl = {branch, memread, memwrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU-control decode plus ALU.
// Ports:
//   aluop_i  - op class from control unit
//   funct_i  - R-type funct field (only meaningful when aluop_i = R-type)
//   a_i, b_i - operands
//   result_o - ALU result (0 for INVALID)
//   zero_o   - result_o == 0, evaluated for every op
module ex_alu
    import mips_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    alu_ctl_e ctl;

    // funct is only examined under the R-type class, so garbage in the
    // immediate's low bits for lw/sw/beq cannot reach the result.
    always_comb begin
        ctl = ALU_INV;
        case (aluop_i)
            ALUOP_MEM: ctl = ALU_ADD;
            ALUOP_BEQ: ctl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: ctl = ALU_ADD;
                    FUNCT_SUB: ctl = ALU_SUB;
                    FUNCT_AND: ctl = ALU_AND;
                    FUNCT_OR:  ctl = ALU_OR;
                    FUNCT_SLT: ctl = ALU_SLT;
                    default:   ctl = ALU_INV;
                endcase
            end
            default: ctl = ALU_INV;
        endcase
    end

    always_comb begin
        result_o = '0;
        case (ctl)
            ALU_ADD: result_o = a_i + b_i;          // wraps, no overflow trap
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o[0] = $signed(a_i) < $signed(b_i);
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/i_execute.sv
// i_execute: EX stage of the 5-stage MIPS pipeline.
// Takes the ID/EX latch outputs, runs the ALU, computes the branch
// target, picks the destination register and registers everything into
// the EX/MEM latch.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall, flush      - hold / bubble the EX/MEM latch (flush wins)
//   wb_ctl, m_ctl     - control bundles, passed through
//   regdst, alusrc    - dest-reg select, operand-B select
//   aluop             - ALU op class
//   npc, rdata1/2     - PC+4 and register operands
//   s_extend          - sign-extended immediate (funct in [5:0])
//   instr_2016/1511   - rt / rd fields
//   ex_mem_*          - registered EX/MEM latch outputs
module i_execute
    import mips_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extend,
    input  logic [REG_W-1:0]  instr_2016,
    input  logic [REG_W-1:0]  instr_1511,
    output logic [1:0]        ex_mem_wb_ctl,
    output logic [2:0]        ex_mem_m_ctl,
    output logic [DATA_W-1:0] ex_mem_add_result,
    output logic              ex_mem_zero,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_rdata2,
    output logic [REG_W-1:0]  ex_mem_rd
);

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res_d;
    logic              zero_d;
    logic [DATA_W-1:0] add_res_d;
    logic [REG_W-1:0]  rd_d;

    logic [1:0]        wb_q;
    logic [2:0]        m_q;
    logic [DATA_W-1:0] add_res_q;
    logic              zero_q;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [REG_W-1:0]  rd_q;

    assign alu_b = alusrc ? s_extend : rdata2;

    ex_alu #(.DATA_W(DATA_W)) u_alu (
        .aluop_i  (aluop),
        .funct_i  (s_extend[5:0]),
        .a_i      (rdata1),
        .b_i      (alu_b),
        .result_o (alu_res_d),
        .zero_o   (zero_d)
    );

    // Word offset -> byte offset; top bits fall off, sum wraps.
    assign add_res_d = npc + (s_extend << 2);
    assign rd_d      = regdst ? instr_1511 : instr_2016;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // A flush bubble is indistinguishable from reset: all control
            // bits clear, so nothing downstream writes or branches.
            wb_q      <= '0;
            m_q       <= '0;
            add_res_q <= '0;
            zero_q    <= 1'b0;
            alu_res_q <= '0;
            rdata2_q  <= '0;
            rd_q      <= '0;
        end else if (!stall) begin
            wb_q      <= wb_ctl;
            m_q       <= m_ctl;
            add_res_q <= add_res_d;
            zero_q    <= zero_d;
            alu_res_q <= alu_res_d;
            rdata2_q  <= rdata2;
            rd_q      <= rd_d;
        end
    end

    assign ex_mem_wb_ctl     = wb_q;
    assign ex_mem_m_ctl      = m_q;
    assign ex_mem_add_result = add_res_q;
    assign ex_mem_zero       = zero_q;
    assign ex_mem_alu_result = alu_res_q;
    assign ex_mem_rdata2     = rdata2_q;
    assign ex_mem_rd         = rd_q;

endmodule

// File: tb/tb_i_execute.sv
module tb_i_execute;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst, alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc, rdata1, rdata2, s_extend;
    logic [4:0]  instr_2016, instr_1511;
    logic [1:0]  o_wb;
    logic [2:0]  o_m;
    logic [31:0] o_add, o_alu, o_rd2;
    logic        o_zero;
    logic [4:0]  o_rd;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  rd;
    } exp_t;

    exp_t sbq[$];
    exp_t prev_exp = '0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    i_execute #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
        .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
        .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .ex_mem_wb_ctl(o_wb), .ex_mem_m_ctl(o_m), .ex_mem_add_result(o_add),
        .ex_mem_zero(o_zero), .ex_mem_alu_result(o_alu),
        .ex_mem_rdata2(o_rd2), .ex_mem_rd(o_rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU written straight from the op table.
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b10) begin
            if (f == 6'h20) return a + b;
            if (f == 6'h22) return a - b;
            if (f == 6'h24) return a & b;
            if (f == 6'h25) return a | b;
            if (f == 6'h2a) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        end
        return 32'd0;
    endfunction

    // Push the expected latch contents for the current inputs, clock once,
    // then pop and compare against what the DUT registered.
    task automatic step(input string tag);
        exp_t e, g;
        logic [31:0] b;
        if (rst || flush) e = '0;
        else if (stall)   e = prev_exp;
        else begin
            b     = alusrc ? s_extend : rdata2;
            e.wb  = wb_ctl;
            e.m   = m_ctl;
            e.alu = ref_alu(aluop, s_extend[5:0], rdata1, b);
            e.zero = (e.alu == 32'd0);
            e.add = npc + {s_extend[29:0], 2'b00};
            e.rd2 = rdata2;
            e.rd  = regdst ? instr_1511 : instr_2016;
        end
        prev_exp = e;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sbq.pop_front();
            chk({tag, ".wb"},   {30'd0, o_wb},   {30'd0, g.wb});
            chk({tag, ".m"},    {29'd0, o_m},    {29'd0, g.m});
            chk({tag, ".add"},  o_add,           g.add);
            chk({tag, ".zero"}, {31'd0, o_zero}, {31'd0, g.zero});
            chk({tag, ".alu"},  o_alu,           g.alu);
            chk({tag, ".rd2"},  o_rd2,           g.rd2);
            chk({tag, ".rd"},   {27'd0, o_rd},   {27'd0, g.rd});
        end
    endtask

    task automatic set_in(input logic [1:0] op, input logic src, input logic dst,
                          input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rd);
        aluop = op; alusrc = src; regdst = dst; rdata1 = a; rdata2 = b2;
        s_extend = imm; npc = pc; instr_2016 = rt; instr_1511 = rd;
    endtask

    task automatic randomize_in();
        wb_ctl = 2'($urandom); m_ctl = 3'($urandom);
        set_in(2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
               $urandom, $urandom, 5'($urandom), 5'($urandom));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        randomize_in();
        #1;
        step("reset");
        step("reset2");

        // release reset with an add
        rst = 1'b0;
        wb_ctl = 2'b10; m_ctl = 3'b000;
        set_in(2'b10, 1'b0, 1'b1, 32'd7, 32'd5, 32'h0000_0020, 32'h40, 5'd3, 5'd9);
        step("radd1");
        if (o_alu !== 32'd12 || o_rd !== 5'd9) chk("radd1.abs", o_alu, 32'd12);

        set_in(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0020, 32'h44, 5'd3, 5'd10);
        step("radd_wrap");
        chk("radd_wrap.zero_abs", {31'd0, o_zero}, 32'd1);

        set_in(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'h0000_002A, 32'h48, 5'd1, 5'd2);
        step("slt_lt");
        chk("slt_lt.abs", o_alu, 32'd1);
        set_in(2'b10, 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFE, 32'h0000_002A, 32'h4C, 5'd1, 5'd2);
        step("slt_ge");
        chk("slt_ge.abs", o_alu, 32'd0);

        set_in(2'b10, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0000_0024, 32'h50, 5'd6, 5'd7);
        step("and");
        set_in(2'b10, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0000_0025, 32'h54, 5'd6, 5'd7);
        step("or");
        set_in(2'b10, 1'b0, 1'b1, 32'd100, 32'd200, 32'h0000_0022, 32'h58, 5'd6, 5'd7);
        step("sub");

        // beq
        wb_ctl = 2'b00; m_ctl = 3'b100;
        set_in(2'b01, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'hFFFF_FFFC, 32'h100, 5'd0, 5'd0);
        step("beq");
        chk("beq.add_abs", o_add, 32'h0000_00F0);

        // lw/sw address: funct bits (8 -> 001000) ignored under aluop 00
        wb_ctl = 2'b11; m_ctl = 3'b010;
        set_in(2'b00, 1'b1, 1'b0, 32'h1000, 32'hCAFE_BABE, 32'd8, 32'h200, 5'd4, 5'd17);
        step("lw");
        chk("lw.alu_abs", o_alu, 32'h1008);
        chk("lw.rd_abs", {27'd0, o_rd}, 32'd4);

        // stall three cycles with changing inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_in();
            step("stall");
        end
        chk("stall.alu_abs", o_alu, 32'h1008);

        // flush wins over stall
        flush = 1'b1;
        randomize_in();
        step("flush_stall");
        flush = 1'b0; stall = 1'b0;

        // invalid funct and reserved aluop
        wb_ctl = 2'b10; m_ctl = 3'b000;
        set_in(2'b10, 1'b0, 1'b1, 32'd5, 32'd6, 32'h0000_0007, 32'h300, 5'd1, 5'd2);
        step("inv_funct");
        chk("inv_funct.zero_abs", {31'd0, o_zero}, 32'd1);
        set_in(2'b11, 1'b0, 1'b1, 32'd5, 32'd6, 32'h0000_0020, 32'h304, 5'd1, 5'd2);
        step("aluop11");

        // reset during a stall, then the stall keeps holding zeros
        set_in(2'b10, 1'b0, 1'b1, 32'd1, 32'd2, 32'h0000_0020, 32'h308, 5'd1, 5'd2);
        step("pre_rst");
        stall = 1'b1; rst = 1'b1;
        randomize_in();
        step("rst_stall");
        rst = 1'b0;
        randomize_in();
        step("stall_after_rst");
        stall = 1'b0;

        // random valid traffic
        for (int i = 0; i < 20; i++) begin
            randomize_in();
            if (aluop == 2'b10 && ($urandom_range(0, 3) != 0)) begin
                case ($urandom_range(0, 4))
                    0: s_extend[5:0] = 6'h20;
                    1: s_extend[5:0] = 6'h22;
                    2: s_extend[5:0] = 6'h24;
                    3: s_extend[5:0] = 6'h25;
                    default: s_extend[5:0] = 6'h2a;
                endcase
            end
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
